// File: rtl/mod_mult_seq.sv
// Sequential modular multiplier: product = (x * y) mod p.
// Processes y MSB-first, one bit per clock, using interleaved double/add with one conditional subtract each.
module mod_mult_seq #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] product_q;

    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH-1:0] dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_red;

    // acc < p holds on entry, so 2*acc < 2p and t + x < 2p: a single subtract always suffices.
    always_comb begin
        p_ext   = {1'b0, p_q};
        dbl     = {acc_q, 1'b0};
        dbl_red = (dbl >= p_ext) ? WIDTH'(dbl - p_ext) : dbl[WIDTH-1:0];
        sum     = {1'b0, dbl_red} + {1'b0, x_q};
        sum_red = (sum >= p_ext) ? WIDTH'(sum - p_ext) : sum[WIDTH-1:0];
        acc_d   = y_q[cnt_q] ? sum_red : dbl_red;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if ((p == '0) || (x >= p)) begin
                            err_q     <= 1'b1;
                            done_q    <= 1'b1;
                            product_q <= '0;
                        end else begin
                            x_q     <= x;
                            y_q     <= y;
                            p_q     <= p;
                            acc_q   <= '0;
                            cnt_q   <= CW'(WIDTH - 1);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign product = product_q;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Self-checking bench for mod_mult_seq at WIDTH=8 and WIDTH=256 (secp256k1 prime).
// Expected results come from a direct multiply-and-modulo model queued at start.
module tb_mod_mult_seq;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef struct {
        logic [255:0] prod;
        logic         err;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start8;
    logic [7:0]   x8, y8, p8, prod8;
    logic         busy8, done8, err8;
    logic         start256;
    logic [255:0] x256, y256, p256, prod256;
    logic         busy256, done256, err256;

    exp_t exp_q8[$];
    exp_t exp_q256[$];
    exp_t e8, e256;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mod_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .reset   (reset),
        .start   (start8),
        .x       (x8),
        .y       (y8),
        .p       (p8),
        .busy    (busy8),
        .done    (done8),
        .err     (err8),
        .product (prod8)
    );

    mod_mult_seq #(.WIDTH(256)) u_dut256 (
        .clk     (clk),
        .reset   (reset),
        .start   (start256),
        .x       (x256),
        .y       (y256),
        .p       (p256),
        .busy    (busy256),
        .done    (done256),
        .err     (err256),
        .product (prod256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] m);
        logic [511:0] w;
        w = ({256'd0, a} * {256'd0, b}) % {256'd0, m};
        return w[255:0];
    endfunction

    // Called #1 after an edge; returns #1 after the edge that sampled start.
    task automatic start_op(input bit wide, input logic [255:0] xa, input logic [255:0] ya,
                            input logic [255:0] pa);
        exp_t e;
        e.err  = (pa == '0) || (xa >= pa);
        e.prod = e.err ? 256'd0 : model(xa, ya, pa);
        if (wide) begin
            x256 = xa; y256 = ya; p256 = pa; start256 = 1'b1;
            exp_q256.push_back(e);
        end else begin
            x8 = xa[7:0]; y8 = ya[7:0]; p8 = pa[7:0]; start8 = 1'b1;
            exp_q8.push_back(e);
        end
        @(posedge clk); #1;
        start8   = 1'b0;
        start256 = 1'b0;
    endtask

    // edges counts the start-sampling edge as 1; bcyc counts sampled cycles with busy high.
    task automatic wait_done(input bit wide, input int budget, output int edges, output int bcyc);
        logic d;
        edges = 1;
        bcyc  = wide ? int'(busy256) : int'(busy8);
        d     = wide ? done256 : done8;
        while (!d && edges < budget) begin
            @(posedge clk); #1;
            edges++;
            bcyc += wide ? int'(busy256) : int'(busy8);
            d = wide ? done256 : done8;
        end
        check_eq(wide ? "d256_done_timeout" : "d8_done_timeout", 256'(d), 256'd1);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (exp_q8.size() == 0) begin
                check_eq("d8_unexpected_done", 256'(done8), 256'd0);
            end else begin
                e8 = exp_q8.pop_front();
                check_eq("d8_product", 256'(prod8), e8.prod);
                check_eq("d8_err", 256'(err8), 256'(e8.err));
            end
        end
    end

    always @(negedge clk) begin
        if (done256) begin
            if (exp_q256.size() == 0) begin
                check_eq("d256_unexpected_done", 256'(done256), 256'd0);
            end else begin
                e256 = exp_q256.pop_front();
                check_eq("d256_product", prod256, e256.prod);
                check_eq("d256_err", 256'(err256), 256'(e256.err));
            end
        end
    end

    initial begin
        int edges, bcyc;
        bit saw_done;
        logic [255:0] rx, ry, rp;

        reset = 1'b1;
        start8 = 1'b1; x8 = 8'd5; y8 = 8'd3; p8 = 8'd7;
        start256 = 1'b0; x256 = '0; y256 = '0; p256 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy8", 256'(busy8), 256'd0);
        check_eq("rst_done8", 256'(done8), 256'd0);
        check_eq("rst_err8", 256'(err8), 256'd0);
        check_eq("rst_prod8", 256'(prod8), 256'd0);
        check_eq("rst_busy256", 256'(busy256), 256'd0);
        check_eq("rst_prod256", prod256, 256'd0);
        start8 = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_busy8", 256'(busy8), 256'd0);

        start_op(0, 200, 100, 251);
        wait_done(0, 40, edges, bcyc);
        check_eq("lat8", 256'(edges), 256'd9);
        check_eq("busy_cycles8", 256'(bcyc), 256'd8);
        @(posedge clk); #1;
        check_eq("done_pulse_width", 256'(done8), 256'd0);

        start_op(0, 5, 9, 0);
        check_eq("pzero_done", 256'(done8), 256'd1);
        check_eq("pzero_err", 256'(err8), 256'd1);
        check_eq("pzero_busy", 256'(busy8), 256'd0);
        check_eq("pzero_prod", 256'(prod8), 256'd0);
        @(posedge clk); #1;
        check_eq("pzero_done_drop", 256'(done8), 256'd0);
        check_eq("pzero_err_hold", 256'(err8), 256'd1);

        start_op(0, 1, 255, 251);
        wait_done(0, 40, edges, bcyc);
        start_op(0, 0, 77, 251);
        check_eq("b2b_accept", 256'(busy8), 256'd1);
        wait_done(0, 40, edges, bcyc);
        check_eq("b2b_lat", 256'(edges), 256'd9);

        start_op(0, 13, 4, 13);
        check_eq("xgep_done", 256'(done8), 256'd1);
        check_eq("xgep_err", 256'(err8), 256'd1);
        check_eq("xgep_busy", 256'(busy8), 256'd0);
        check_eq("xgep_prod", 256'(prod8), 256'd0);
        @(posedge clk); #1;

        // Start pulses with fresh operands during RUN cycles 2 and 5 must be ignored.
        start_op(0, 200, 100, 251);
        @(posedge clk); #1;
        start8 = 1'b1; x8 = 8'd7; y8 = 8'd9; p8 = 8'd11;
        @(posedge clk); #1;
        start8 = 1'b0; x8 = 8'd250; y8 = 8'd1; p8 = 8'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start8 = 1'b1; x8 = 8'd1; y8 = 8'd2; p8 = 8'd0;
        @(posedge clk); #1;
        start8 = 1'b0;
        check_eq("ignore_busy", 256'(busy8), 256'd1);
        wait_done(0, 40, edges, bcyc);
        @(posedge clk); #1;

        start_op(0, 200, 100, 251);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 256'(busy8), 256'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 256'(busy8), 256'd0);
        check_eq("mid_rst_done", 256'(done8), 256'd0);
        check_eq("mid_rst_err", 256'(err8), 256'd0);
        check_eq("mid_rst_prod", 256'(prod8), 256'd0);
        exp_q8.delete();
        @(negedge clk) reset = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done8) saw_done = 1'b1;
        end
        check_eq("mid_rst_no_done", 256'(saw_done), 256'd0);
        start_op(0, 123, 45, 251);
        wait_done(0, 40, edges, bcyc);
        check_eq("post_rst_lat", 256'(edges), 256'd9);

        for (int i = 0; i < 6; i++) begin
            rp = 256'($urandom_range(1, 255));
            rx = 256'($urandom) % rp;
            ry = 256'($urandom_range(0, 255));
            start_op(0, rx, ry, rp);
            wait_done(0, 40, edges, bcyc);
        end

        start_op(1, P256 - 256'd1, P256 - 256'd1, P256);
        wait_done(1, 400, edges, bcyc);
        check_eq("lat256", 256'(edges), 256'd257);
        check_eq("busy_cycles256", 256'(bcyc), 256'd256);
        start_op(1, 256'd2, 256'd3, P256);
        wait_done(1, 400, edges, bcyc);
        start_op(1, P256, 256'd3, P256);
        check_eq("d256_xgep_err", 256'(err256), 256'd1);
        for (int i = 0; i < 2; i++) begin
            rx = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % P256;
            ry = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            start_op(1, rx, ry, P256);
            wait_done(1, 400, edges, bcyc);
        end

        @(posedge clk); #1;
        check_eq("sb8_drained", 256'(exp_q8.size()), 256'd0);
        check_eq("sb256_drained", 256'(exp_q256.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
